// File: rtl/four_req_rr_arbiter.sv
// Four-requester round-robin arbiter with a registered, held output stage.
// Define FOUR_REQ_RR_ARBITER_STATS_EN to add saturating per-requester grant counters.
module four_req_rr_arbiter #(
  parameter int DATA_W = 8,
  parameter int STAT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            req_valid,
  input  logic [4*DATA_W-1:0]   req_data,
  output logic [3:0]            req_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [1:0]            out_id,
  input  logic                  out_ready,
  output logic                  busy
`ifdef FOUR_REQ_RR_ARBITER_STATS_EN
  ,
  output logic [4*STAT_W-1:0]   grant_cnt
`endif
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state;
  logic [1:0]        last_id;
  logic [1:0]        winner;
  logic              has_winner;
  logic [DATA_W-1:0] req_data_arr [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_unpack
      assign req_data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Scan from the farthest offset down so the nearest requester after last_id wins.
  always_comb begin
    winner     = last_id;
    has_winner = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req_valid[last_id + 2'(k + 1)]) begin
        winner     = last_id + 2'(k + 1);
        has_winner = 1'b1;
      end
    end
  end

  // Depends only on state and requests, never on out_ready.
  assign req_ready = (rst_n && (state == IDLE) && has_winner) ? (4'b0001 << winner) : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= 2'd0;
      busy      <= 1'b0;
      last_id   <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          if (has_winner) begin
            out_data  <= req_data_arr[winner];
            out_id    <= winner;
            last_id   <= winner;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FOUR_REQ_RR_ARBITER_STATS_EN
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cnt
      logic [STAT_W-1:0] cnt;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (req_valid[gi] && req_ready[gi] && (cnt != {STAT_W{1'b1}})) begin
          cnt <= cnt + 1'b1;
        end
      end
      assign grant_cnt[gi*STAT_W +: STAT_W] = cnt;
    end
  endgenerate
`else
  logic unused_stat_w;
  assign unused_stat_w = ^STAT_W;
`endif

endmodule
